mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, word width; VLEN, 4, beats per vector access.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk in 1: single clock, rising edge.
- rst in 1: synchronous, active-low reset.
- if_req in 1: instruction fetch request.
- if_addr in ADDR_W: fetch address.
- if_rdata out DATA_W: fetched word.
- if_valid out 1: fetch complete, one-cycle pulse.
- d_req in 1: data request.
- d_we in 1: data request is a write.
- d_vec in 1: data request is a vector access of VLEN beats.
- d_addr in ADDR_W: data base address.
- d_wdata in DATA_W: write word for the current beat.
- d_beat out clog2(VLEN): current beat index.
- d_rdata out DATA_W: read word.
- d_valid out 1: beat complete, one-cycle pulse.
- d_done out 1: transaction complete, one-cycle pulse.
- stall out 1: pipeline stall.
- mem_req out 1: memory request.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_rdata in DATA_W: memory read data.
- mem_ack in 1: memory beat accepted/complete.

Function
REQ-003 The block SHALL implement the FSM states IDLE, FETCH and DATA.
REQ-004 In IDLE, a pending d_req SHALL move the FSM to DATA and otherwise a pending if_req SHALL move it to FETCH. The fairness rule in REQ-011 overrides this.
REQ-005 On entering FETCH or DATA, the block SHALL latch the requester's address, we and vec. mem_req SHALL assert the next cycle, with mem_addr and mem_we held stable until mem_ack.
REQ-006 In FETCH, on the mem_ack cycle, the block SHALL register mem_rdata into if_rdata and pulse if_valid for one cycle on the following cycle. The FSM SHALL then return to IDLE.
REQ-007 In DATA, scalar access: one beat, mem_addr = latched d_addr. On mem_ack, the block SHALL pulse d_valid and d_done together the next cycle, with d_rdata registered (reads only).
REQ-008 In DATA, vector access: VLEN beats.
- Beat k SHALL use mem_addr = base + 4*k, with modulo 2^ADDR_W wrap.
- d_beat SHALL equal k and mem_wdata SHALL equal d_wdata while beat k is outstanding.
- Each mem_ack SHALL advance k and pulse d_valid.
- d_done SHALL pulse with the d_valid of beat VLEN-1.
- The FSM SHALL then return to IDLE.
REQ-009 mem_req SHALL deassert for at least one cycle (the IDLE turnaround) between transactions, and mem_ack received while mem_req=0 SHALL be ignored.
REQ-010 A requester dropping its req mid-transaction SHALL NOT abort the transaction. Requesters SHALL hold req until if_valid or d_done, and a req still high in the cycle after completion SHALL be treated as a new request.
REQ-011 Fairness:
- A 2-bit counter SHALL count consecutive DATA grants made while if_req was pending.
- When the count reaches 2, the next IDLE decision SHALL grant FETCH.
- The counter SHALL clear on any FETCH grant, or when if_req is low at a grant decision.
REQ-012 stall SHALL be combinationally asserted when if_req=1 and (the FSM is not in FETCH or mem_ack=0). It SHALL be low in the cycle the fetch mem_ack arrives.
REQ-013 A simultaneous if_req and d_req in IDLE SHALL grant DATA, unless REQ-011 applies. The losing request SHALL remain pending and SHALL NOT be dropped.
REQ-014 mem_ack held high across consecutive beats SHALL complete one beat per cycle, with no lost or duplicated beats.

Reset
REQ-015 When rst=0 at a clock edge, the state SHALL be IDLE, and the beat counter, fairness counter and latched fields SHALL be zero. The following outputs SHALL be 0: mem_req, mem_we, mem_addr, mem_wdata, if_valid, d_valid, d_done, if_rdata, d_rdata, d_beat.
REQ-016 Reset asserted mid-transaction SHALL abort it: mem_req SHALL be 0 the cycle after the reset edge, and no valid or done pulse SHALL be produced for the aborted transaction.

Structure
REQ-017 The state enum, VLEN default and word-stride constant (4) SHALL reside in the shared processor package.
REQ-018 The beat counter and address generator SHALL be a sub-module, mem_beat_counter, with inputs for load base, advance and last-beat detect.

Verification
REQ-019 Scalar fetch: if_req=1, if_addr=0x100, mem_ack after 2 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100; if_valid pulses once with if_rdata=0xDEADBEEF; stall is low on the ack cycle.
REQ-020 Vector read: d_vec=1, d_addr=0x200, mem_ack held high -> mem_addr sequence 0x200, 0x204, 0x208, 0x20C; four d_valid pulses; d_done with the fourth.
REQ-021 Simultaneous and fairness: if_req=1 and d_req=1 held for 3 transactions -> grant order DATA, DATA, FETCH.
REQ-022 Address wrap: vector write at d_addr=0xFFFFFFF8 -> mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; mem_we=1 and mem_wdata matches d_wdata for each d_beat.
REQ-023 Reset mid-burst: rst=0 during beat 2 of a vector read -> mem_req=0 on the next cycle, no d_done, and all outputs at REQ-015 values.
REQ-024 Spurious ack: mem_ack=1 while in IDLE -> no valid or done pulse and no state change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

    localparam int         VLEN_DEFAULT = 4;
    localparam int         WORD_STRIDE  = 4;
    localparam logic [1:0] FAIR_LIMIT   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_beat_counter
// Description : Beat index and word-stride address generator for one access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_beat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int VLEN   = VLEN_DEFAULT,
    parameter int BEAT_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              advance_i,
    input  logic              vec_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        beat_d = beat_q;
        addr_d = addr_q;
        if (load_i) begin
            beat_d = '0;
            addr_d = base_i;
        end else if (advance_i) begin
            beat_d = beat_q + BEAT_W'(1);
            addr_d = addr_q + ADDR_W'(WORD_STRIDE);   // wraps modulo 2^ADDR_W
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_q <= '0;
            addr_q <= '0;
        end else begin
            beat_q <= beat_d;
            addr_q <= addr_d;
        end
    end

    assign beat_o = beat_q;
    assign addr_o = addr_q;
    assign last_o = !vec_i || (beat_q == BEAT_W'(VLEN - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data
//               (scalar or vector) requesters with a fetch-fairness rule.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int   ADDR_W = 32,
    parameter int   DATA_W = 32,
    parameter int   VLEN   = VLEN_DEFAULT,
    localparam int  BEAT_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_vec,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [BEAT_W-1:0] d_beat,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_done,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_e        state_q, state_d;
    logic [1:0]        fair_q, fair_d;
    logic              we_q, vec_q;
    logic              if_valid_q, d_valid_q, d_done_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              grant_fetch, grant_data;
    logic              beat_last;
    logic              fetch_ack, data_ack;

    assign fetch_ack = (state_q == ST_FETCH) && mem_ack;
    assign data_ack  = (state_q == ST_DATA)  && mem_ack;

    // The IDLE cycle carrying a completion pulse makes no grant, so a
    // requester still holding req there is not re-served by accident.
    always_comb begin
        state_d     = state_q;
        fair_d      = fair_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!if_valid_q && !d_done_q) begin
                    if (if_req && (fair_q == FAIR_LIMIT || !d_req)) begin
                        grant_fetch = 1'b1;
                        state_d     = ST_FETCH;
                        fair_d      = 2'd0;
                    end else if (d_req) begin
                        grant_data = 1'b1;
                        state_d    = ST_DATA;
                        fair_d     = if_req ? fair_q + 2'd1 : 2'd0;
                    end
                end
            end
            ST_FETCH: if (mem_ack) state_d = ST_IDLE;
            ST_DATA:  if (mem_ack && beat_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fair_q     <= 2'd0;
            we_q       <= 1'b0;
            vec_q      <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            fair_q     <= fair_d;
            if_valid_q <= fetch_ack;
            d_valid_q  <= data_ack;
            d_done_q   <= data_ack && beat_last;
            if (grant_fetch) begin
                we_q  <= 1'b0;
                vec_q <= 1'b0;
            end else if (grant_data) begin
                we_q  <= d_we;
                vec_q <= d_vec;
            end
            if (fetch_ack)
                if_rdata_q <= mem_rdata;
            if (data_ack && !we_q)
                d_rdata_q <= mem_rdata;
        end
    end

    mem_beat_counter #(
        .ADDR_W (ADDR_W),
        .VLEN   (VLEN),
        .BEAT_W (BEAT_W)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (grant_fetch || grant_data),
        .base_i    (grant_data ? d_addr : if_addr),
        .advance_i (data_ack && !beat_last),
        .vec_i     (vec_q),
        .beat_o    (d_beat),
        .addr_o    (mem_addr),
        .last_o    (beat_last)
    );

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = mem_req && we_q;
    assign mem_wdata = ((state_q == ST_DATA) && we_q) ? d_wdata : '0;
    assign stall     = if_req && !fetch_ack;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req, d_we, d_vec;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_beat;
    logic [31:0] d_rdata;
    logic        d_valid, d_done, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wrap_addr [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .VLEN(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_vec(d_vec), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_beat(d_beat), .d_rdata(d_rdata), .d_valid(d_valid), .d_done(d_done),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " mem_req"},   64'(mem_req),   64'd0);
        check_eq({tag, " mem_we"},    64'(mem_we),    64'd0);
        check_eq({tag, " mem_addr"},  64'(mem_addr),  64'd0);
        check_eq({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_eq({tag, " if_valid"},  64'(if_valid),  64'd0);
        check_eq({tag, " d_valid"},   64'(d_valid),   64'd0);
        check_eq({tag, " d_done"},    64'(d_done),    64'd0);
        check_eq({tag, " if_rdata"},  64'(if_rdata),  64'd0);
        check_eq({tag, " d_rdata"},   64'(d_rdata),   64'd0);
        check_eq({tag, " d_beat"},    64'(d_beat),    64'd0);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_vec = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        cyc(); cyc();
        #1 check_idle_outputs("reset");

        // Scalar fetch, ack two cycles after mem_req rises
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        #1 check_eq("fetch stall idle", 64'(stall), 64'd1);
        cyc();
        #1 check_eq("fetch mem_req", 64'(mem_req), 64'd1);
        check_eq("fetch mem_addr", 64'(mem_addr), 64'h100);
        check_eq("fetch mem_we", 64'(mem_we), 64'd0);
        check_eq("fetch stall wait", 64'(stall), 64'd1);
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 check_eq("fetch stall ack", 64'(stall), 64'd0);
        check_eq("fetch mem_addr held", 64'(mem_addr), 64'h100);
        cyc();
        mem_ack = 1'b0; if_req = 1'b0;
        #1 check_eq("fetch if_valid", 64'(if_valid), 64'd1);
        check_eq("fetch if_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
        check_eq("fetch turnaround", 64'(mem_req), 64'd0);
        cyc();
        #1 check_eq("fetch if_valid pulse", 64'(if_valid), 64'd0);

        // Vector read with ack held high
        d_req = 1'b1; d_vec = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        cyc();
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'hA0 + 32'(k);
            #1 check_eq("vrd mem_req", 64'(mem_req), 64'd1);
            check_eq("vrd mem_addr", 64'(mem_addr), 64'(32'h200 + 32'(4 * k)));
            check_eq("vrd d_beat", 64'(d_beat), 64'(k));
            cyc();
            check_eq("vrd d_valid", 64'(d_valid), 64'd1);
            check_eq("vrd d_rdata", 64'(d_rdata), 64'(32'hA0 + 32'(k)));
            check_eq("vrd d_done", 64'(d_done), 64'(k == 3));
        end
        mem_ack = 1'b0; d_req = 1'b0; d_vec = 1'b0;
        #1 check_eq("vrd turnaround", 64'(mem_req), 64'd0);
        cyc();
        #1 check_eq("vrd d_valid end", 64'(d_valid), 64'd0);
        check_eq("vrd d_done end", 64'(d_done), 64'd0);

        // Simultaneous requests: expect DATA, DATA, FETCH
        if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_addr = 32'h300;
        mem_rdata = 32'h5555_0000;
        for (int t = 0; t < 3; t++) begin
            cyc();
            #1 check_eq("fair mem_addr", 64'(mem_addr), (t == 2) ? 64'h400 : 64'h300);
            check_eq("fair stall", 64'(stall), 64'd1);
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
            #1 check_eq("fair d_done", 64'(d_done), 64'(t != 2));
            check_eq("fair if_valid", 64'(if_valid), 64'(t == 2));
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        check_eq("fair d_rdata", 64'(d_rdata), 64'h5555_0000);

        // Vector write wrapping the address space
        d_req = 1'b1; d_vec = 1'b1; d_we = 1'b1; d_addr = 32'hFFFF_FFF8;
        mem_rdata = 32'h0BAD_0000;
        cyc();
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_wdata = 32'h1000 + 32'(k);
            #1 check_eq("vwr mem_addr", 64'(mem_addr), 64'(wrap_addr[k]));
            check_eq("vwr mem_we", 64'(mem_we), 64'd1);
            check_eq("vwr mem_wdata", 64'(mem_wdata), 64'(32'h1000 + 32'(k)));
            check_eq("vwr d_beat", 64'(d_beat), 64'(k));
            cyc();
            check_eq("vwr d_valid", 64'(d_valid), 64'd1);
        end
        mem_ack = 1'b0; d_req = 1'b0;
        #1 check_eq("vwr d_done", 64'(d_done), 64'd1);
        check_eq("vwr d_rdata kept", 64'(d_rdata), 64'h5555_0000);
        cyc();

        // Reset during beat 2 of a vector read
        d_req = 1'b1; d_vec = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        cyc();
        mem_ack = 1'b1;
        cyc(); cyc();
        #1 check_eq("rst beat", 64'(d_beat), 64'd2);
        check_eq("rst addr", 64'(mem_addr), 64'h508);
        rst = 1'b0;
        cyc();
        #1 check_idle_outputs("midrst");
        rst = 1'b1; d_req = 1'b0; d_vec = 1'b0; mem_ack = 1'b0;
        cyc();
        #1 check_eq("midrst d_done", 64'(d_done), 64'd0);
        check_eq("midrst d_valid", 64'(d_valid), 64'd0);
        check_eq("midrst mem_req", 64'(mem_req), 64'd0);

        // Spurious acks while idle
        mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1 check_eq("spur mem_req", 64'(mem_req), 64'd0);
            check_eq("spur if_valid", 64'(if_valid), 64'd0);
            check_eq("spur d_valid", 64'(d_valid), 64'd0);
            check_eq("spur d_done", 64'(d_done), 64'd0);
        end
        mem_ack = 1'b0;

        // Fetch after spurious acks behaves normally
        if_req = 1'b1; if_addr = 32'h600;
        cyc();
        #1 check_eq("post mem_addr", 64'(mem_addr), 64'h600);
        check_eq("post mem_req", 64'(mem_req), 64'd1);
        if_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        cyc();
        mem_ack = 1'b0;
        #1 check_eq("post if_valid", 64'(if_valid), 64'd1);
        check_eq("post if_rdata", 64'(if_rdata), 64'h1234_5678);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
